// File: rtl/regfile_pkg.sv
// Shared constants, FSM state type and port slicing helper for the multi-port
// integer register file.
package regfile_pkg;

  localparam int unsigned ZERO_REG_ADDR = 0;
  localparam int unsigned XLEN_DEF      = 32;
  localparam int unsigned NREG_DEF      = 32;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  // Low bit index of port idx inside a flattened bus of width-bit fields.
  function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One registered read port: captures an address on enable, bypasses a same-edge
// write, and refreshes a held output whenever its captured register is written.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF,
  parameter int unsigned AW   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clk_en,
  input  logic            force_zero,
  input  logic [AW-1:0]   addr,
  input  logic [XLEN-1:0] rf_data,
  input  logic            w_valid,
  input  logic [AW-1:0]   rd,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] rdata
);

  logic [AW-1:0] addr_q;
  logic          addr_zero;

  assign addr_zero = (addr == AW'(ZERO_REG_ADDR));

  // w_valid never targets x0, so a held x0 output is never refreshed.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      rdata  <= '0;
    end else if (clk_en) begin
      addr_q <= addr;
      if (force_zero || addr_zero) begin
        rdata <= '0;
      end else if (w_valid && (rd == addr)) begin
        rdata <= wdata;
      end else begin
        rdata <= rf_data;
      end
    end else if (w_valid && (rd == addr_q)) begin
      rdata <= wdata;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port RV32I register file with registered reads, write bypass,
// pending-write scoreboard and a post-reset zero-clear sweep.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN           = XLEN_DEF,
  parameter int unsigned NREG           = NREG_DEF,
  parameter int unsigned NUM_RD         = 2,
  parameter int unsigned CLEAR_ON_RESET = 1,
  localparam int unsigned AW            = $clog2(NREG)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clk_en_read,
  input  logic [NUM_RD*AW-1:0]   rs_addr,
  output logic [NUM_RD*XLEN-1:0] rs_rdata,
  output logic [NUM_RD-1:0]      rs_busy,
  input  logic                   w_en,
  input  logic [AW-1:0]          rd,
  input  logic [XLEN-1:0]        rd_wdata,
  input  logic                   issue_en,
  input  logic [AW-1:0]          issue_rd,
  output logic                   ready
);

  localparam logic [AW-1:0] LAST_REG = AW'(NREG - 1);

  state_e          state_q, state_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic            sweep_we;
  logic [XLEN-1:0] rf [NREG];
  logic [NREG-1:0] busy_q, busy_d;
  logic            running;
  logic            w_valid;
  logic            i_valid;

  assign running = (state_q == ST_RUN);
  assign w_valid = running && w_en && (rd != AW'(ZERO_REG_ADDR)) && (32'(rd) < NREG);
  assign i_valid = running && issue_en && (issue_rd != AW'(ZERO_REG_ADDR)) && (32'(issue_rd) < NREG);

  // Sweep FSM: walk x1..x(NREG-1) writing zero, then run.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    sweep_we = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        sweep_we = 1'b1;
        ptr_d    = ptr_q + AW'(1);
        if (ptr_q == LAST_REG) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
      ptr_q   <= AW'(1);
      ready   <= 1'b0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ready   <= (state_d == ST_RUN);
      busy_q  <= busy_d;
    end
  end

  // Architectural storage carries no reset; the sweep provides zeros.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (sweep_we) begin
        rf[ptr_q] <= '0;
      end else if (w_valid) begin
        rf[rd] <= rd_wdata;
      end
    end
  end

  // Scoreboard: issue sets, writeback clears, a same-register issue wins.
  always_comb begin
    busy_d = busy_q;
    if (w_valid) begin
      busy_d[rd] = 1'b0;
    end
    if (i_valid) begin
      busy_d[issue_rd] = 1'b1;
    end
    busy_d[ZERO_REG_ADDR] = 1'b0;
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    localparam int unsigned ALO = slice_lo(i, AW);
    localparam int unsigned DLO = slice_lo(i, XLEN);

    logic [AW-1:0]   a;
    logic            a_ok;
    logic [XLEN-1:0] rf_data;
    logic            wb_clears;

    assign a         = rs_addr[ALO +: AW];
    assign a_ok      = (a != AW'(ZERO_REG_ADDR)) && (32'(a) < NREG);
    assign rf_data   = a_ok ? rf[a] : '0;
    assign wb_clears = w_valid && (rd == a) && !(i_valid && (issue_rd == rd));
    assign rs_busy[i] = a_ok && busy_q[a] && !wb_clears;

    regfile_read_port #(
      .XLEN(XLEN),
      .AW  (AW)
    ) u_port (
      .clk       (clk),
      .rst       (rst),
      .clk_en    (clk_en_read),
      .force_zero(state_q == ST_CLEAR),
      .addr      (a),
      .rf_data   (rf_data),
      .w_valid   (w_valid),
      .rd        (rd),
      .wdata     (rd_wdata),
      .rdata     (rs_rdata[DLO +: XLEN])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed and random checks of regfile_mp against an array-level reference model.
module tb_regfile_mp;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned NREG   = 32;
  localparam int unsigned NUM_RD = 2;
  localparam int unsigned AW     = 5;
  localparam int unsigned SWEEP  = NREG - 1;

  logic                   clk;
  logic                   rst;
  logic                   clk_en_read;
  logic [NUM_RD*AW-1:0]   rs_addr;
  logic [NUM_RD*XLEN-1:0] rs_rdata;
  logic [NUM_RD-1:0]      rs_busy;
  logic                   w_en;
  logic [AW-1:0]          rd;
  logic [XLEN-1:0]        rd_wdata;
  logic                   issue_en;
  logic [AW-1:0]          issue_rd;
  logic                   ready;

  regfile_mp #(
    .XLEN          (XLEN),
    .NREG          (NREG),
    .NUM_RD        (NUM_RD),
    .CLEAR_ON_RESET(1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clk_en_read(clk_en_read),
    .rs_addr    (rs_addr),
    .rs_rdata   (rs_rdata),
    .rs_busy    (rs_busy),
    .w_en       (w_en),
    .rd         (rd),
    .rd_wdata   (rd_wdata),
    .issue_en   (issue_en),
    .issue_rd   (issue_rd),
    .ready      (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [XLEN-1:0] mem     [NREG];
  bit              busy_m  [NREG];
  logic [AW-1:0]   cap     [NUM_RD];
  logic [XLEN-1:0] exp_out [NUM_RD];
  bit              exp_ready;
  int              run_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_rs(input int p, input logic [AW-1:0] a);
    rs_addr[p*AW +: AW] = a;
  endtask

  task automatic idle();
    clk_en_read = 1'b0;
    w_en        = 1'b0;
    rd          = '0;
    rd_wdata    = '0;
    issue_en    = 1'b0;
    issue_rd    = '0;
  endtask

  task automatic model_reset();
    for (int r = 0; r < NREG; r++) begin
      mem[r]    = '0;
      busy_m[r] = 1'b0;
    end
    for (int p = 0; p < NUM_RD; p++) begin
      cap[p]     = '0;
      exp_out[p] = '0;
    end
    exp_ready = 1'b0;
    run_cnt   = 0;
  endtask

  // One clock: check combinational busy before the edge, advance the model, check registers after.
  task automatic cycle();
    logic [AW-1:0] a;
    bit            wv, iv, eb;
    wv = exp_ready && w_en && (rd != 0);
    iv = exp_ready && issue_en && (issue_rd != 0);
    #1;
    if (!rst) begin
      for (int p = 0; p < NUM_RD; p++) begin
        a  = rs_addr[p*AW +: AW];
        eb = (a != 0) && busy_m[a] && !(wv && (rd == a) && !(iv && (issue_rd == a)));
        chk($sformatf("rs_busy%0d@x%0d", p, a), 32'(rs_busy[p]), 32'(eb));
      end
    end
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      for (int p = 0; p < NUM_RD; p++) begin
        if (clk_en_read) begin
          a      = rs_addr[p*AW +: AW];
          cap[p] = a;
          if (a == 0)                  exp_out[p] = '0;
          else if (wv && (rd == a))    exp_out[p] = rd_wdata;
          else                         exp_out[p] = mem[a];
        end else if (wv && (rd == cap[p])) begin
          exp_out[p] = rd_wdata;
        end
      end
      if (wv) begin
        mem[rd]    = rd_wdata;
        busy_m[rd] = 1'b0;
      end
      if (iv) busy_m[issue_rd] = 1'b1;
      run_cnt++;
      exp_ready = (run_cnt >= SWEEP);
    end
    #1;
    chk("ready", 32'(ready), 32'(exp_ready));
    for (int p = 0; p < NUM_RD; p++) begin
      chk($sformatf("rs_rdata%0d", p), rs_rdata[p*XLEN +: XLEN], exp_out[p]);
    end
  endtask

  initial begin
    rst     = 1'b1;
    rs_addr = '0;
    idle();
    model_reset();

    // Reset, then sweep with a write attempt to x5 that must be dropped
    cycle();
    cycle();
    rst = 1'b0;
    for (int k = 0; k < SWEEP; k++) begin
      idle();
      if (k == 3) begin
        w_en = 1'b1; rd = AW'(5); rd_wdata = 32'hAAAA_5555;
        issue_en = 1'b1; issue_rd = AW'(6);
      end
      cycle();
    end
    idle();

    // Every register reads zero after the sweep
    clk_en_read = 1'b1;
    for (int r = 0; r < NREG; r++) begin
      set_rs(0, AW'(r));
      set_rs(1, AW'(NREG - 1 - r));
      cycle();
    end

    // Same-edge write and read through bypass; port 1 on x0
    clk_en_read = 1'b1; set_rs(0, AW'(7)); set_rs(1, AW'(0));
    w_en = 1'b1; rd = AW'(7); rd_wdata = 32'hDEAD_BEEF;
    cycle();
    idle();
    cycle();

    // Held output refreshes on a write to its captured register
    clk_en_read = 1'b1; set_rs(0, AW'(3)); set_rs(1, AW'(7));
    cycle();
    idle();
    set_rs(0, AW'(20));
    w_en = 1'b1; rd = AW'(3); rd_wdata = 32'h1234_5678;
    cycle();
    idle();
    cycle();

    // Scoreboard set, same-cycle clear, and set-wins collision
    set_rs(0, AW'(9)); set_rs(1, AW'(9));
    issue_en = 1'b1; issue_rd = AW'(9);
    cycle();
    idle();
    cycle();
    w_en = 1'b1; rd = AW'(9); rd_wdata = 32'h0000_0009;
    cycle();
    idle();
    cycle();
    issue_en = 1'b1; issue_rd = AW'(9);
    cycle();
    w_en = 1'b1; rd = AW'(9); rd_wdata = 32'h0000_0099;
    cycle();
    idle();
    clk_en_read = 1'b1;
    cycle();

    // x0 writes and issues have no effect
    idle();
    clk_en_read = 1'b1; set_rs(0, AW'(0)); set_rs(1, AW'(0));
    w_en = 1'b1; rd = AW'(0); rd_wdata = 32'hFFFF_FFFF;
    issue_en = 1'b1; issue_rd = AW'(0);
    cycle();
    idle();
    cycle();

    // Reset in RUN with busy bits set
    issue_en = 1'b1; issue_rd = AW'(12);
    cycle();
    issue_rd = AW'(13);
    set_rs(0, AW'(12)); set_rs(1, AW'(13));
    cycle();
    idle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    // Reset again mid-sweep once ptr has reached 10
    for (int k = 0; k < 9; k++) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    for (int k = 0; k < SWEEP + 2; k++) begin
      w_en = 1'b1; rd = AW'(k % NREG); rd_wdata = 32'(k) ^ 32'h5A5A_0000;
      clk_en_read = 1'b1;
      cycle();
    end
    idle();

    // Randomized traffic
    for (int k = 0; k < 800; k++) begin
      rst         = ($urandom_range(0, 299) == 0);
      clk_en_read = ($urandom_range(0, 1) == 1);
      set_rs(0, AW'($urandom_range(0, NREG - 1)));
      set_rs(1, ($urandom_range(0, 3) == 0) ? rs_addr[0 +: AW] : AW'($urandom_range(0, NREG - 1)));
      w_en        = ($urandom_range(0, 1) == 1);
      rd          = AW'($urandom_range(0, 15));
      rd_wdata    = $urandom;
      issue_en    = ($urandom_range(0, 2) == 0);
      issue_rd    = ($urandom_range(0, 3) == 0) ? rd : AW'($urandom_range(0, 15));
      cycle();
    end
    rst = 1'b0;
    idle();
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
